ysyx_23060201_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060201_mem_arbiter

Overview:
- Two-to-one memory arbiter that shares the single data-memory port between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Sits between IFU/LSU and the memory/bus wrapper that replaces the direct pmem DPI calls.
- Serialises transactions: only one outstanding request at a time.
- Responses are returned to the requester that was granted.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width. Mask width is DATA_WIDTH/8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_WIDTH  fetch address.
- ifu_resp_valid  out  1  one-cycle pulse: ifu_rdata valid.
- ifu_rdata  out  DATA_WIDTH  fetched instruction.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_WIDTH  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_WIDTH  store data.
- lsu_wmask  in  DATA_WIDTH/8  byte write mask.
- lsu_resp_valid  out  1  one-cycle pulse: load data valid, or store complete.
- lsu_rdata  out  DATA_WIDTH  load data.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream accepts request.
- mem_addr  out  ADDR_WIDTH  latched address.
- mem_wen  out  1  latched write enable; forced 0 for IFU.
- mem_wdata  out  DATA_WIDTH  latched store data.
- mem_wmask  out  DATA_WIDTH/8  latched mask; all zero for IFU.
- mem_resp_valid  in  1  downstream response valid.
- mem_resp_ready  out  1  arbiter accepts response.
- mem_rdata  in  DATA_WIDTH  downstream read data.

Behaviour:
- Three-state FSM: IDLE, REQ, RESP.
- Reset is asynchronous. On reset:
  - state = IDLE, owner = IFU, last_grant = IFU.
  - Latched addr/wdata/wmask/wen = 0.
  - All valid/ready outputs = 0.
  - Any in-flight transaction is dropped. A late mem_resp_valid after reset is ignored because the FSM is in IDLE.
- IDLE:
  - Pick a winner combinationally from the two req_valid inputs.
  - Default policy is fixed priority: LSU wins when both are valid.
  - Winner's req_ready = 1 in the same cycle; the loser's req_ready = 0.
  - On that edge, latch addr/wen/wdata/wmask and owner, then go to REQ.
  - No valid request: stay in IDLE.
- REQ:
  - mem_req_valid = 1, driven with the latched fields. Fields stay stable until accepted.
  - On mem_req_valid && mem_req_ready, go to RESP.
  - Both requester readys are 0.
- RESP:
  - mem_resp_ready = 1.
  - On mem_resp_valid:
    - Owner's resp_valid = 1 for that cycle only, combinationally.
    - Owner's rdata = mem_rdata. A store gets rdata = mem_rdata, which is don't-care.
    - Return to IDLE.
- mem_resp_valid outside RESP is ignored.
- Minimum latency is 2 cycles:
  - Accept at cycle T.
  - mem_req_valid at T+1. If mem_req_ready is high, enter RESP at T+2.
  - resp_valid at T+2 at the earliest, if memory responds in the same cycle.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after the response.
- Requesters must hold req_valid and fields until req_ready. They must accept resp_valid unconditionally; there is no resp backpressure.
- Non-owner resp_valid is always 0. Non-owner rdata is 0.
- last_grant updates on every accept.

Optional Feature:
- Macro: YSYX_23060201_ARB_RR_EN.
- Defined: round-robin. When both requesters are valid in IDLE, grant the one that is not last_grant. A single valid requester is granted regardless.
- Undefined: fixed priority, LSU over IFU. last_grant is still maintained but unused.

Decomposition:
- Shared package/defines header holds:
  - State encodings ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_RESP=2'd2.
  - Owner IDs ARB_OWNER_IFU=1'b0, ARB_OWNER_LSU=1'b1.
- One sub-module, ysyx_23060201_arb_pick:
  - Purely combinational winner select.
  - Inputs: two valids, last_grant. Outputs: grant_ifu, grant_lsu.
  - Contains the ARB_RR_EN branch.
- FSM and latches stay in the top module.

Test Plan:
- Single IFU fetch: ifu addr 0x80000000, memory ready immediately, rdata 0x00000413.
  -> ifu_req_ready at T, mem_addr = 0x80000000 with mem_wen = 0 at T+1, ifu_resp_valid with 0x00000413 at T+2, lsu_resp_valid stays 0.
- Simultaneous requests: IFU 0x80000004 and LSU load 0x80001000, both valid.
  -> Fixed mode: LSU granted first, IFU second.
  -> RR mode with last_grant = LSU: IFU first.
- LSU store: addr 0x80002000, wdata 0xDEADBEEF, wmask 4'b0011, mem_req_ready delayed 3 cycles.
  -> mem_* fields stable for all 3 cycles, mem_wen = 1, lsu_resp_valid is a single pulse on mem_resp_valid.
- Slow memory: response 5 cycles after accept while ifu_req_valid is held.
  -> ifu_req_ready stays 0 until the IDLE cycle after the response.
  -> Stray mem_resp_valid pulses while in IDLE/REQ produce no resp_valid.
- Reset mid-operation: assert rst asynchronously while in RESP.
  -> All outputs 0 immediately. After release, mem_resp_valid = 1 with no requests produces no resp_valid, and the FSM stays IDLE.
- RR fairness (ARB_RR_EN): both requesters continuously valid for 8 transactions.
  -> Grants alternate IFU/LSU exactly 4 each.

Source files
------------

// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states and owner IDs.
package ysyx_23060201_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic ARB_OWNER_IFU = 1'b0;
    localparam logic ARB_OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060201_arb_pick.sv
// Combinational winner select for the memory arbiter.
// Define YSYX_23060201_ARB_RR_EN for round-robin; otherwise LSU has fixed priority.
module ysyx_23060201_arb_pick
    import ysyx_23060201_mem_arbiter_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_grant,
    output logic grant_ifu,
    output logic grant_lsu
);

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
`ifdef YSYX_23060201_ARB_RR_EN
        if (ifu_valid && lsu_valid) begin
            // On contention, hand the port to whoever did not win last time.
            grant_lsu = (last_grant == ARB_OWNER_IFU);
            grant_ifu = !grant_lsu;
        end else begin
            grant_ifu = ifu_valid;
            grant_lsu = lsu_valid;
        end
`else
        grant_lsu = lsu_valid;
        grant_ifu = ifu_valid && !lsu_valid;
`endif
    end

`ifndef YSYX_23060201_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Two-to-one IFU/LSU arbiter for the single data-memory port, one transaction at a time.
// Optional round-robin arbitration via YSYX_23060201_ARB_RR_EN (see ysyx_23060201_arb_pick).
module ysyx_23060201_mem_arbiter
    import ysyx_23060201_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,

    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    output logic                    mem_resp_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    arb_state_e              state_q, state_d;
    logic                    owner_q;
    logic                    last_grant_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wen_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wmask_q;

    logic grant_ifu, grant_lsu, accept;

    ysyx_23060201_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant_q),
        .grant_ifu  (grant_ifu),
        .grant_lsu  (grant_lsu)
    );

    assign accept = (state_q == ARB_IDLE) && (grant_ifu || grant_lsu);

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    always_comb begin
        state_d        = state_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        unique case (state_q)
            ARB_IDLE: begin
                // Readys are gated by rst so nothing looks accepted while reset is held.
                ifu_req_ready = grant_ifu && !rst;
                lsu_req_ready = grant_lsu && !rst;
                if (accept) state_d = ARB_REQ;
            end
            ARB_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = ARB_RESP;
            end
            ARB_RESP: begin
                mem_resp_ready = 1'b1;
                if (mem_resp_valid) begin
                    state_d = ARB_IDLE;
                    if (owner_q == ARB_OWNER_LSU) begin
                        lsu_resp_valid = 1'b1;
                        lsu_rdata      = mem_rdata;
                    end else begin
                        ifu_resp_valid = 1'b1;
                        ifu_rdata      = mem_rdata;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= ARB_OWNER_IFU;
            last_grant_q <= ARB_OWNER_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant_lsu ? ARB_OWNER_LSU : ARB_OWNER_IFU;
                last_grant_q <= grant_lsu ? ARB_OWNER_LSU : ARB_OWNER_IFU;
                if (grant_lsu) begin
                    addr_q  <= lsu_addr;
                    wen_q   <= lsu_wen;
                    wdata_q <= lsu_wdata;
                    wmask_q <= lsu_wmask;
                end else begin
                    // Fetches are always reads with an empty mask.
                    addr_q  <= ifu_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Self-checking bench for ysyx_23060201_mem_arbiter: per-cycle vector table plus
// hand-written sequences for contention, slow memory, async reset and round-robin.
module tb_ysyx_23060201_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_23060201_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_rdata      (mem_rdata)
    );

    // ctl = {ifu_v, lsu_v, lsu_wen, mem_req_ready, mem_resp_valid}
    // exp = {ifu_rdy, lsu_rdy, mem_req_valid, mem_wen, mem_resp_ready, ifu_rv, lsu_rv}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] ia;
        logic [31:0] la;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [31:0] mrd;
        logic [6:0]  exp;
        logic [31:0] e_ma;
        logic [31:0] e_wd;
        logic [3:0]  e_wm;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ifu_req_ready"}, 32'(ifu_req_ready), 32'd0);
        chk({tag, " lsu_req_ready"}, 32'(lsu_req_ready), 32'd0);
        chk({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, " mem_resp_ready"}, 32'(mem_resp_ready), 32'd0);
        chk({tag, " ifu_resp_valid"}, 32'(ifu_resp_valid), 32'd0);
        chk({tag, " lsu_resp_valid"}, 32'(lsu_resp_valid), 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_wen"}, 32'(mem_wen), 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " mem_wmask"}, 32'(mem_wmask), 32'd0);
    endtask

    initial begin
        logic        first_ifu;
        logic [31:0] a_first, a_second;
        string       s;

        // Single fetch, contention (LSU wins in both modes since last_grant is IFU),
        // store with 3 stalled REQ cycles and stray responses in REQ and IDLE.
        tbl[0]  = '{5'b10010, 32'h80000000, 0, 0, 4'h0, 0, 7'b1000000, 0, 0, 4'h0, 0};
        tbl[1]  = '{5'b00010, 0, 0, 0, 4'h0, 0, 7'b0010000, 32'h80000000, 0, 4'h0, 0};
        tbl[2]  = '{5'b00001, 0, 0, 0, 4'h0, 32'h00000413, 7'b0000110, 0, 0, 4'h0, 32'h00000413};
        tbl[3]  = '{5'b11000, 32'h80000004, 32'h80001000, 0, 4'h0, 0, 7'b0100000, 0, 0, 4'h0, 0};
        tbl[4]  = '{5'b10010, 32'h80000004, 0, 0, 4'h0, 0, 7'b0010000, 32'h80001000, 0, 4'h0, 0};
        tbl[5]  = '{5'b10001, 32'h80000004, 0, 0, 4'h0, 32'h11112222, 7'b0000101, 0, 0, 4'h0,
                    32'h11112222};
        tbl[6]  = '{5'b10000, 32'h80000004, 0, 0, 4'h0, 0, 7'b1000000, 0, 0, 4'h0, 0};
        tbl[7]  = '{5'b00010, 0, 0, 0, 4'h0, 0, 7'b0010000, 32'h80000004, 0, 4'h0, 0};
        tbl[8]  = '{5'b00001, 0, 0, 0, 4'h0, 32'h33334444, 7'b0000110, 0, 0, 4'h0, 32'h33334444};
        tbl[9]  = '{5'b01100, 0, 32'h80002000, 32'hDEADBEEF, 4'b0011, 0, 7'b0100000, 0, 0, 4'h0, 0};
        tbl[10] = '{5'b00000, 0, 0, 0, 4'h0, 0, 7'b0011000, 32'h80002000, 32'hDEADBEEF, 4'b0011, 0};
        tbl[11] = '{5'b00001, 0, 0, 0, 4'h0, 32'h55555555, 7'b0011000, 32'h80002000, 32'hDEADBEEF,
                    4'b0011, 0};
        tbl[12] = '{5'b00000, 0, 0, 0, 4'h0, 0, 7'b0011000, 32'h80002000, 32'hDEADBEEF, 4'b0011, 0};
        tbl[13] = '{5'b00010, 0, 0, 0, 4'h0, 0, 7'b0011000, 32'h80002000, 32'hDEADBEEF, 4'b0011, 0};
        tbl[14] = '{5'b00000, 0, 0, 0, 4'h0, 0, 7'b0000100, 0, 0, 4'h0, 0};
        tbl[15] = '{5'b00001, 0, 0, 0, 4'h0, 32'h0BADF00D, 7'b0000101, 0, 0, 4'h0, 32'h0BADF00D};
        tbl[16] = '{5'b00001, 0, 0, 0, 4'h0, 32'h77777777, 7'b0000000, 0, 0, 4'h0, 0};
        tbl[17] = '{5'b00000, 0, 0, 0, 4'h0, 0, 7'b0000000, 0, 0, 4'h0, 0};

        // Reset state, with an IFU request pending to show readys are held low.
        idle_inputs();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h80000000;
        rst = 1'b1;
        cyc();
        cyc();
        chk_all_zero("reset");
        idle_inputs();
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 18; i++) begin
            ifu_req_valid  = tbl[i].ctl[4];
            lsu_req_valid  = tbl[i].ctl[3];
            lsu_wen        = tbl[i].ctl[2];
            mem_req_ready  = tbl[i].ctl[1];
            mem_resp_valid = tbl[i].ctl[0];
            ifu_addr       = tbl[i].ia;
            lsu_addr       = tbl[i].la;
            lsu_wdata      = tbl[i].wd;
            lsu_wmask      = tbl[i].wm;
            mem_rdata      = tbl[i].mrd;
            #1;
            s = $sformatf("vec%0d", i);
            chk({s, " ifu_req_ready"}, 32'(ifu_req_ready), 32'(tbl[i].exp[6]));
            chk({s, " lsu_req_ready"}, 32'(lsu_req_ready), 32'(tbl[i].exp[5]));
            chk({s, " mem_req_valid"}, 32'(mem_req_valid), 32'(tbl[i].exp[4]));
            chk({s, " mem_resp_ready"}, 32'(mem_resp_ready), 32'(tbl[i].exp[2]));
            chk({s, " ifu_resp_valid"}, 32'(ifu_resp_valid), 32'(tbl[i].exp[1]));
            chk({s, " lsu_resp_valid"}, 32'(lsu_resp_valid), 32'(tbl[i].exp[0]));
            if (tbl[i].exp[4]) begin
                chk({s, " mem_addr"}, mem_addr, tbl[i].e_ma);
                chk({s, " mem_wen"}, 32'(mem_wen), 32'(tbl[i].exp[3]));
                chk({s, " mem_wdata"}, mem_wdata, tbl[i].e_wd);
                chk({s, " mem_wmask"}, 32'(mem_wmask), 32'(tbl[i].e_wm));
            end
            if (tbl[i].exp[1]) begin
                chk({s, " ifu_rdata"}, ifu_rdata, tbl[i].e_rd);
                chk({s, " lsu_rdata non-owner"}, lsu_rdata, 32'd0);
            end
            if (tbl[i].exp[0]) begin
                chk({s, " lsu_rdata"}, lsu_rdata, tbl[i].e_rd);
                chk({s, " ifu_rdata non-owner"}, ifu_rdata, 32'd0);
            end
            cyc();
        end

        // Contention with last_grant = LSU: fixed priority still picks LSU, RR picks IFU.
`ifdef YSYX_23060201_ARB_RR_EN
        first_ifu = 1'b1;
`else
        first_ifu = 1'b0;
`endif
        a_first  = first_ifu ? 32'h80000010 : 32'h80001004;
        a_second = first_ifu ? 32'h80001004 : 32'h80000010;
        idle_inputs();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h80000010;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h80001004;
        mem_req_ready = 1'b1;
        #1;
        chk("contend ifu_req_ready", 32'(ifu_req_ready), 32'(first_ifu));
        chk("contend lsu_req_ready", 32'(lsu_req_ready), 32'(!first_ifu));
        cyc();
        if (first_ifu) ifu_req_valid = 1'b0;
        else           lsu_req_valid = 1'b0;
        #1;
        chk("contend first mem_addr", mem_addr, a_first);
        cyc();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hA5A5A5A5;
        #1;
        chk("contend first ifu_resp_valid", 32'(ifu_resp_valid), 32'(first_ifu));
        chk("contend first lsu_resp_valid", 32'(lsu_resp_valid), 32'(!first_ifu));
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        chk("contend second ifu_req_ready", 32'(ifu_req_ready), 32'(!first_ifu));
        chk("contend second lsu_req_ready", 32'(lsu_req_ready), 32'(first_ifu));
        cyc();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        #1;
        chk("contend second mem_addr", mem_addr, a_second);
        cyc();
        mem_resp_valid = 1'b1;
        #1;
        chk("contend second ifu_resp_valid", 32'(ifu_resp_valid), 32'(!first_ifu));
        chk("contend second lsu_resp_valid", 32'(lsu_resp_valid), 32'(first_ifu));
        cyc();

        // Slow memory: response 5 cycles after accept with ifu_req_valid held throughout.
        idle_inputs();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h80000008;
        mem_req_ready = 1'b1;
        #1;
        chk("slow accept ifu_req_ready", 32'(ifu_req_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("slow T+%0d ifu_req_ready", k), 32'(ifu_req_ready), 32'd0);
            chk($sformatf("slow T+%0d ifu_resp_valid", k), 32'(ifu_resp_valid), 32'd0);
        end
        cyc();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h00100073;
        #1;
        chk("slow T+5 ifu_req_ready", 32'(ifu_req_ready), 32'd0);
        chk("slow T+5 ifu_resp_valid", 32'(ifu_resp_valid), 32'd1);
        chk("slow T+5 ifu_rdata", ifu_rdata, 32'h00100073);
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        chk("slow T+6 ifu_req_ready", 32'(ifu_req_ready), 32'd1);

        // That re-accepted fetch is in REQ next cycle, then RESP; reset it mid-flight.
        cyc();
        cyc();
        chk("pre-reset mem_resp_ready", 32'(mem_resp_ready), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        cyc();
        idle_inputs();
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFFFFFF;
        #1;
        chk("late resp ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
        chk("late resp lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
        chk("late resp mem_resp_ready", 32'(mem_resp_ready), 32'd0);
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        chk("post-reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("post-reset mem_resp_ready", 32'(mem_resp_ready), 32'd0);

`ifdef YSYX_23060201_ARB_RR_EN
        // Fairness: last_grant is IFU after reset, so grants run LSU, IFU, LSU, ...
        begin
            int n_ifu = 0;
            int n_lsu = 0;
            ifu_req_valid = 1'b1;
            ifu_addr      = 32'h80000100;
            lsu_req_valid = 1'b1;
            lsu_addr      = 32'h80003000;
            mem_req_ready = 1'b1;
            for (int t = 0; t < 8; t++) begin
                mem_resp_valid = 1'b0;
                #1;
                chk($sformatf("rr%0d lsu_req_ready", t), 32'(lsu_req_ready), 32'(t % 2 == 0));
                chk($sformatf("rr%0d ifu_req_ready", t), 32'(ifu_req_ready), 32'(t % 2 == 1));
                if (ifu_req_ready) n_ifu++;
                if (lsu_req_ready) n_lsu++;
                cyc();
                cyc();
                mem_resp_valid = 1'b1;
                cyc();
            end
            mem_resp_valid = 1'b0;
            chk("rr ifu grant count", 32'(n_ifu), 32'd4);
            chk("rr lsu grant count", 32'(n_lsu), 32'd4);
            idle_inputs();
            cyc();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
